// File: rtl/alu_md_control_pkg.sv
// Shared encodings for the EX-stage ALU decode and the mult/div sequencer.
package alu_md_control_pkg;

  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_OR  = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_SLTU = 4'b1000;
  localparam logic [3:0] CTL_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // R-type funct to ALU control; unlisted functs (including mult/div/move) run an ADD.
  function automatic logic [3:0] rtype_ctrl(input logic [5:0] funct);
    case (funct)
      F_ADD:   rtype_ctrl = CTL_ADD;
      F_SUB:   rtype_ctrl = CTL_SUB;
      F_AND:   rtype_ctrl = CTL_AND;
      F_OR:    rtype_ctrl = CTL_OR;
      F_XOR:   rtype_ctrl = CTL_XOR;
      F_NOR:   rtype_ctrl = CTL_NOR;
      F_SLT:   rtype_ctrl = CTL_SLT;
      F_SLTU:  rtype_ctrl = CTL_SLTU;
      default: rtype_ctrl = CTL_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_md_control_md_iter_unit.sv
// Iterative unsigned multiply / restoring divide datapath, one bit per step.
// After DATA_W steps: mult -> {acc, sr} is the product; div -> sr = quotient, acc = remainder.
module md_iter_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a_mag,
  input  logic [DATA_W-1:0] b_mag,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] sr,
  output logic              last
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] divisor;
  logic              div_mode;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;

  // Candidate next values for one shift-add and one trial subtraction.
  always_comb begin
    sum    = {1'b0, acc} + (sr[0] ? {1'b0, divisor} : '0);
    rem_sh = {acc, sr[DATA_W-1]};
    diff   = rem_sh - {1'b0, divisor};
  end

  // Operand load, per-step update and down-counting iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      sr       <= '0;
      divisor  <= '0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      acc      <= '0;
      sr       <= a_mag;
      divisor  <= b_mag;
      div_mode <= is_div;
      cnt      <= CNT_W'(DATA_W - 1);
    end else if (step) begin
      if (div_mode) begin
        // With a zero divisor both branches keep rem_sh, so acc ends up holding the dividend.
        if (!diff[DATA_W]) begin
          acc <= diff[DATA_W-1:0];
          sr  <= {sr[DATA_W-2:0], 1'b1};
        end else begin
          acc <= rem_sh[DATA_W-1:0];
          sr  <= {sr[DATA_W-2:0], 1'b0};
        end
      end else begin
        acc <= sum[DATA_W:1];
        sr  <= {sum[0], sr[DATA_W-1:1]};
      end
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/alu_md_control.sv
// EX-stage ALU control decode plus mult/div sequencer with HI/LO and pipeline stall.
//
//  state   | meaning
//  IDLE    | no mult/div in flight; accepts mult/div, mthi/mtlo, serves mfhi/mflo
//  BUSY    | one iteration per cycle until the counter reaches zero
//  FIX     | sign correction, HI/LO write, done_q set for the following cycle
module alu_md_control
  import alu_md_control_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        campoFuncion,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic [CTRL_W-1:0] controlDeALU,
  output logic [DATA_W-1:0] md_result,
  output logic              stall,
  output logic              div_zero
);

  md_state_t           state, state_nxt;
  logic [3:0]          ctrl4;
  logic                rtype;
  logic                is_mult, is_divop, is_md, is_mf, is_mt, is_signed;
  logic                sign_a, sign_b, accept;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W-1:0]   hi, lo, hi_fix, lo_fix;
  logic [DATA_W-1:0]   acc, sr;
  logic                last, done_q;
  logic                neg_res, neg_rem, op_div, op_div0;
  logic [2*DATA_W-1:0] prod;

  // ALU control decode; an unknown ALUOp[0] with ALUOp[1]=1 falls through to R-type.
  always_comb begin
    ctrl4 = CTL_ADD;
    rtype = 1'b0;
    if (ALUOp == ALUOP_OR) begin
      ctrl4 = CTL_OR;
    end else if (ALUOp[1]) begin
      rtype = 1'b1;
      ctrl4 = rtype_ctrl(campoFuncion);
    end else if (ALUOp == ALUOP_SUB) begin
      ctrl4 = CTL_SUB;
    end
  end

  assign controlDeALU = CTRL_W'(ctrl4);

  assign is_mult   = rtype & ((campoFuncion == F_MULT) | (campoFuncion == F_MULTU));
  assign is_divop  = rtype & ((campoFuncion == F_DIV)  | (campoFuncion == F_DIVU));
  assign is_md     = is_mult | is_divop;
  assign is_mf     = rtype & ((campoFuncion == F_MFHI) | (campoFuncion == F_MFLO));
  assign is_mt     = rtype & ((campoFuncion == F_MTHI) | (campoFuncion == F_MTLO));
  assign is_signed = (campoFuncion == F_MULT) | (campoFuncion == F_DIV);
  assign sign_a    = is_signed & opA[DATA_W-1];
  assign sign_b    = is_signed & opB[DATA_W-1];
  assign a_mag     = sign_a ? ('0 - opA) : opA;
  assign b_mag     = sign_b ? ('0 - opB) : opB;
  assign accept    = (state == ST_IDLE) & start & is_md & ~done_q & ~flush;

  md_iter_unit #(.DATA_W(DATA_W)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (state == ST_BUSY),
    .is_div (is_divop),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc),
    .sr     (sr),
    .last   (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nxt = ST_BUSY;
        ST_BUSY: if (last)   state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stall and HI/LO read port; stall is forced low while reset is asserted.
  always_comb begin
    stall     = 1'b0;
    md_result = '0;
    if (rst_n) begin
      stall = (state != ST_IDLE)
            | ((state == ST_IDLE) & start & is_md & ~done_q)
            | (start & (is_mf | is_mt) & (state != ST_IDLE));
    end
    if (start & is_mf & (state == ST_IDLE)) begin
      md_result = (campoFuncion == F_MFHI) ? hi : lo;
    end
  end

  // Sign correction of the raw iteration result for the FIX write.
  always_comb begin
    prod = {acc, sr};
    if (neg_res) prod = '0 - prod;
    hi_fix = prod[2*DATA_W-1:DATA_W];
    lo_fix = prod[DATA_W-1:0];
    if (op_div) begin
      lo_fix = op_div0 ? '1 : (neg_res ? ('0 - sr) : sr);
      hi_fix = neg_rem ? ('0 - acc) : acc;
    end
  end

  // Operation attributes captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      op_div  <= 1'b0;
      op_div0 <= 1'b0;
    end else if (accept) begin
      neg_res <= sign_a ^ sign_b;
      neg_rem <= sign_a;
      op_div  <= is_divop;
      op_div0 <= is_divop & (opB == '0);
    end
  end

  // HI/LO writes from FIX or mthi/mtlo in IDLE; a flush suppresses both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush) begin
      if (state == ST_FIX) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end else if ((state == ST_IDLE) & start & is_mt) begin
        if (campoFuncion == F_MTHI) hi <= opA;
        else                        lo <= opA;
      end
    end
  end

  // One-cycle completion flags following FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done_q   <= (state == ST_FIX) & ~flush;
      div_zero <= (state == ST_FIX) & op_div0 & ~flush;
    end
  end

endmodule

// File: tb/tb_alu_md_control.sv
// Bench for alu_md_control: cycle model from arithmetic rules, directed cases, random traffic.
module tb_alu_md_control;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    ALUOp = 2'b00;
  logic [5:0]    campoFuncion = 6'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  opA = '0;
  logic [W-1:0]  opB = '0;
  logic [3:0]    controlDeALU;
  logic [W-1:0]  md_result;
  logic          stall;
  logic          div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_md_control #(.DATA_W(W), .CTRL_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ALUOp        (ALUOp),
    .campoFuncion (campoFuncion),
    .start        (start),
    .flush        (flush),
    .opA          (opA),
    .opB          (opB),
    .controlDeALU (controlDeALU),
    .md_result    (md_result),
    .stall        (stall),
    .div_zero     (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ctrl_ref(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    case (f)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100110: return 4'b0011;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      6'b101011: return 4'b1000;
      default:   return 4'b0010;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  int           m_rem;      // cycles left before the result lands (0 = nothing in flight)
  bit           m_done, m_dz, p_dz;

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_rem = 0; m_done = 0; m_dz = 0;
  endtask

  task automatic compute_result(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p_dz = 0;
    case (f)
      6'b011000: begin p = sa * sb; u = p; p_hi = u[63:32]; p_lo = u[31:0]; end
      6'b011001: begin u = {32'b0, a} * {32'b0, b}; p_hi = u[63:32]; p_lo = u[31:0]; end
      6'b011010: begin
        if (b == 0) begin p_lo = '1; p_hi = a; p_dz = 1; end
        else begin q = sa / sb; r = sa % sb; u = q; p_lo = u[31:0]; u = r; p_hi = u[31:0]; end
      end
      default: begin
        if (b == 0) begin p_lo = '1; p_hi = a; p_dz = 1; end
        else begin p_lo = a / b; p_hi = a % b; end
      end
    endcase
  endtask

  // Compare process: check at negedge, advance the model at posedge.
  initial begin
    bit rt, md, mf;
    logic [W-1:0] e_res;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      rt = (ALUOp == 2'b10);
      md = rt && (campoFuncion inside {6'b011000, 6'b011001, 6'b011010, 6'b011011});
      mf = rt && (campoFuncion inside {6'b010000, 6'b010010});
      e_res = (start && mf && m_rem == 0) ? ((campoFuncion == 6'b010000) ? m_hi : m_lo) : '0;
      chk("model_ctrl", 64'(controlDeALU), 64'(ctrl_ref(ALUOp, campoFuncion)));
      chk("model_stall", 64'(stall), 64'(rst_n && (m_rem > 0 || (start && md && !m_done))));
      chk("model_md_result", 64'(md_result), 64'(e_res));
      chk("model_div_zero", 64'(div_zero), 64'(m_dz));
      @(posedge clk);
      if (!rst_n) model_reset();
      else if (flush) begin
        m_rem = 0; m_done = 0; m_dz = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dz = p_dz;
        end else begin
          m_done = 0; m_dz = 0;
        end
      end else begin
        if (start && md && !m_done) begin
          compute_result(campoFuncion, opA, opB);
          m_rem = W + 1;
        end else if (start && rt && campoFuncion == 6'b010001) m_hi = opA;
        else if (start && rt && campoFuncion == 6'b010011) m_lo = opA;
        m_done = 0; m_dz = 0;
      end
    end
  end

  // ---------------- directed driver ----------------
  task automatic run(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int sw_at, input logic [5:0] sw_f,
                     input int fl_at, output int stalls, output logic [W-1:0] res, output bit dz);
    int cyc;
    @(posedge clk); #1;
    ALUOp = op; campoFuncion = f; opA = a; opB = b; start = 1'b1; flush = 1'b0;
    stalls = 0; dz = 0; cyc = 0; res = '0;
    forever begin
      @(negedge clk);
      if (div_zero) dz = 1;
      res = md_result;
      if (!stall) break;
      stalls++;
      if (stalls > 100) begin
        chk("run_timeout", 64'(stalls), 64'd100);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc == sw_at) campoFuncion = sw_f;
      flush = (cyc == fl_at);
      if (flush) start = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom % 5)
      0: return W'($urandom_range(0, 40));
      1: return '0 - W'($urandom_range(1, 40));
      2: return '0;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int st;
    logic [W-1:0] r;
    bit dz;
    logic [1:0] d_op [9] = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] d_f  [9] = '{6'b101010, 6'b100100, 6'b0, 6'b0, 6'b0, 6'b100111, 6'b011000, 6'b100110, 6'b101011};
    logic [3:0] d_e  [9] = '{4'b0111, 4'b0000, 4'b0110, 4'b0001, 4'b0010, 4'b1100, 4'b0010, 4'b0011, 4'b1000};
    logic [5:0] pool [16] = '{6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b011000, 6'b011001,
                              6'b011010, 6'b011011, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100110, 6'b100111, 6'b101010, 6'b101011};
    bit held;

    // Reset: pending mult on the inputs must not stall while rst_n is low.
    ALUOp = 2'b10; campoFuncion = 6'b011000; start = 1'b1;
    #2;
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_div_zero", 64'(div_zero), 64'd0);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ALUOp = d_op[i]; campoFuncion = d_f[i];
      #1;
      chk("decode", 64'(controlDeALU), 64'(d_e[i]));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // mult -3 * 7
    run(2'b10, 6'b011000, -32'sd3, 32'd7, -1, 6'b0, -1, st, r, dz);
    chk("mult_stall_cycles", 64'(st), 64'd34);
    run(2'b10, 6'b010000, '0, '0, -1, 6'b0, -1, st, r, dz);
    chk("mult_hi", 64'(r), 64'hFFFFFFFF);
    chk("mfhi_no_stall", 64'(st), 64'd0);
    run(2'b10, 6'b010010, '0, '0, -1, 6'b0, -1, st, r, dz);
    chk("mult_lo", 64'(r), 64'hFFFFFFEB);

    // div -7 / 2
    run(2'b10, 6'b011010, -32'sd7, 32'd2, -1, 6'b0, -1, st, r, dz);
    chk("div_no_dz", 64'(dz), 64'd0);
    run(2'b10, 6'b010010, '0, '0, -1, 6'b0, -1, st, r, dz);
    chk("div_lo", 64'(r), 64'hFFFFFFFD);
    run(2'b10, 6'b010000, '0, '0, -1, 6'b0, -1, st, r, dz);
    chk("div_hi", 64'(r), 64'hFFFFFFFF);

    // divu 7 / 0
    run(2'b10, 6'b011011, 32'd7, 32'd0, -1, 6'b0, -1, st, r, dz);
    chk("divu0_dz", 64'(dz), 64'd1);
    run(2'b10, 6'b010010, '0, '0, -1, 6'b0, -1, st, r, dz);
    chk("divu0_lo", 64'(r), 64'hFFFFFFFF);
    run(2'b10, 6'b010000, '0, '0, -1, 6'b0, -1, st, r, dz);
    chk("divu0_hi", 64'(r), 64'd7);

    // mflo replaces the mult in EX while busy; it must see the new LO.
    run(2'b10, 6'b011000, 32'd5, 32'd6, 5, 6'b010010, -1, st, r, dz);
    chk("mflo_busy_stall", 64'(st), 64'd34);
    chk("mflo_busy_result", 64'(r), 64'd30);

    // flush during BUSY of a divide-by-zero: no write, no pulse
    run(2'b10, 6'b010001, 32'h1234, '0, -1, 6'b0, -1, st, r, dz);
    run(2'b10, 6'b011011, 32'd9, 32'd0, -1, 6'b0, 10, st, r, dz);
    chk("flush_stall_cycles", 64'(st), 64'd11);
    chk("flush_no_dz", 64'(dz), 64'd0);
    run(2'b10, 6'b010000, '0, '0, -1, 6'b0, -1, st, r, dz);
    chk("flush_hi_kept", 64'(r), 64'h1234);
    run(2'b10, 6'b010010, '0, '0, -1, 6'b0, -1, st, r, dz);
    chk("flush_lo_kept", 64'(r), 64'd30);

    // reset in the middle of BUSY
    @(posedge clk); #1;
    ALUOp = 2'b10; campoFuncion = 6'b011000; opA = 32'd3; opB = 32'd3; start = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0; campoFuncion = 6'b010000;
    #1;
    chk("rst_mid_stall", 64'(stall), 64'd0);
    chk("rst_mid_hi", 64'(md_result), 64'd0);
    campoFuncion = 6'b010010;
    #1;
    chk("rst_mid_lo", 64'(md_result), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    run(2'b10, 6'b010001, 32'd5, '0, -1, 6'b0, -1, st, r, dz);
    run(2'b10, 6'b010000, '0, '0, -1, 6'b0, -1, st, r, dz);
    chk("mthi_mfhi", 64'(r), 64'd5);

    // random traffic, instruction held in EX while stall is high
    held = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (!held) begin
        start = ($urandom % 8) != 0;
        ALUOp = (($urandom % 4) == 0) ? 2'($urandom) : 2'b10;
        campoFuncion = (($urandom % 6) == 0) ? 6'($urandom) : pool[$urandom % 16];
        if (campoFuncion inside {6'b011000, 6'b011001, 6'b011010, 6'b011011} && ($urandom % 3) != 0)
          campoFuncion = 6'b010000 | 6'($urandom % 4);
        opA = rand_op();
        opB = rand_op();
      end
      flush = ($urandom % 60) == 0;
      @(negedge clk);
      held = stall;
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
